// File: rtl/linebuffer_ctrl_if.sv
// Signal bundle between the scanline timing/renderer side and the line-buffer controller.
// Names follow the pin names of the controller; the master drives timing/render inputs.
interface linebuffer_ctrl_if;
  logic       HSYNC_START;
  logic       PIX_LOAD;
  logic [7:0] PIX_X;
  logic       PIX_VALID;
  logic       LDX_A;
  logic       LDX_B;
  logic [7:0] XPOS_A;
  logic [7:0] XPOS_B;
  logic       WE_A;
  logic       WE_B;
  logic       MODE_A;
  logic       MODE_B;
  logic       SEL;
  logic       DISP_VALID;
  logic       CLR_EN;
  logic       LINE_ERR;
  logic       WR_DROP;

  modport master (
    output HSYNC_START, PIX_LOAD, PIX_X, PIX_VALID,
    input  LDX_A, LDX_B, XPOS_A, XPOS_B, WE_A, WE_B, MODE_A, MODE_B,
           SEL, DISP_VALID, CLR_EN, LINE_ERR, WR_DROP
  );

  modport slave (
    input  HSYNC_START, PIX_LOAD, PIX_X, PIX_VALID,
    output LDX_A, LDX_B, XPOS_A, XPOS_B, WE_A, WE_B, MODE_A, MODE_B,
           SEL, DISP_VALID, CLR_EN, LINE_ERR, WR_DROP
  );
endinterface

// File: rtl/linebuffer_ctrl.sv
// Double-buffered sprite line-buffer controller: one buffer is rendered while the other
// is read out to the display and then cleared; the roles swap on every HSYNC_START.
module linebuffer_ctrl #(
  parameter int DISP_START = 8,
  parameter int LB_LEN     = 192
) (
  input  logic              CK,
  input  logic              RESET,
  linebuffer_ctrl_if.slave  bus,
  output logic [1:0]        dbg_state_o
);
  localparam int CW = 9;
  localparam logic [CW-1:0] WAIT_LDX  = CW'(DISP_START - 2);
  localparam logic [CW-1:0] WAIT_LAST = CW'(DISP_START - 1);
  localparam logic [CW-1:0] LINE_LDX  = CW'(LB_LEN - 2);
  localparam logic [CW-1:0] LINE_LAST = CW'(LB_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READ  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          pos_valid_q, pos_valid_d;
  logic          ldx_a_q, ldx_a_d, ldx_b_q, ldx_b_d;
  logic [7:0]    xpos_a_q, xpos_a_d, xpos_b_q, xpos_b_d;
  logic          we_a_q, we_a_d, we_b_q, we_b_d;
  logic          mode_a_q, mode_a_d, mode_b_q, mode_b_d;
  logic          disp_valid_q, disp_valid_d;
  logic          clr_en_q, clr_en_d;
  logic          line_err_q, line_err_d;
  logic          wr_drop_q, wr_drop_d;

  // Display-side and render-side intents for the next cycle, before routing to A/B.
  logic          d_ldx, d_mode, d_we;
  logic          r_ldx, r_we;
  logic [7:0]    r_x;

  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      pos_valid_q  <= 1'b0;
      ldx_a_q      <= 1'b0;
      ldx_b_q      <= 1'b0;
      xpos_a_q     <= 8'd0;
      xpos_b_q     <= 8'd0;
      we_a_q       <= 1'b0;
      we_b_q       <= 1'b0;
      mode_a_q     <= 1'b0;
      mode_b_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      clr_en_q     <= 1'b0;
      line_err_q   <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      pos_valid_q  <= pos_valid_d;
      ldx_a_q      <= ldx_a_d;
      ldx_b_q      <= ldx_b_d;
      xpos_a_q     <= xpos_a_d;
      xpos_b_q     <= xpos_b_d;
      we_a_q       <= we_a_d;
      we_b_q       <= we_b_d;
      mode_a_q     <= mode_a_d;
      mode_b_q     <= mode_b_d;
      disp_valid_q <= disp_valid_d;
      clr_en_q     <= clr_en_d;
      line_err_q   <= line_err_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  // Display FSM: outputs computed here are the registered values for the following cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    d_ldx        = 1'b0;
    d_mode       = 1'b0;
    d_we         = 1'b0;
    disp_valid_d = 1'b0;
    clr_en_d     = 1'b0;
    line_err_d   = 1'b0;
    if (bus.HSYNC_START) begin
      sel_d      = ~sel_q;
      state_d    = ST_WAIT;
      cnt_d      = '0;
      line_err_d = (state_q == ST_READ) || (state_q == ST_CLEAR);
    end else begin
      case (state_q)
        ST_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == WAIT_LDX) d_ldx = 1'b1;
          if (cnt_q == WAIT_LAST) begin
            state_d      = ST_READ;
            cnt_d        = '0;
            d_mode       = 1'b1;
            disp_valid_d = 1'b1;
          end
        end
        ST_READ: begin
          cnt_d        = cnt_q + 1'b1;
          d_mode       = 1'b1;
          disp_valid_d = 1'b1;
          // Rewind the counter during the final read so clearing starts at entry 0.
          if (cnt_q == LINE_LDX) d_ldx = 1'b1;
          if (cnt_q == LINE_LAST) begin
            state_d      = ST_CLEAR;
            cnt_d        = '0;
            d_mode       = 1'b0;
            disp_valid_d = 1'b0;
            d_we         = 1'b1;
            clr_en_d     = 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_d    = cnt_q + 1'b1;
          d_we     = 1'b1;
          clr_en_d = 1'b1;
          if (cnt_q == LINE_LAST) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            d_we     = 1'b0;
            clr_en_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Render pipeline targets the pre-swap render buffer (sel_q); display targets sel_d.
  always_comb begin
    r_ldx       = bus.PIX_LOAD;
    r_x         = bus.PIX_LOAD ? bus.PIX_X : 8'd0;
    r_we        = bus.PIX_VALID & ~bus.PIX_LOAD & pos_valid_q;
    wr_drop_d   = bus.PIX_VALID & (bus.PIX_LOAD | ~pos_valid_q);
    pos_valid_d = bus.HSYNC_START ? 1'b0 : (bus.PIX_LOAD | pos_valid_q);
    ldx_a_d     = (~sel_q & r_ldx) | (sel_d & d_ldx);
    ldx_b_d     = (sel_q & r_ldx) | (~sel_d & d_ldx);
    xpos_a_d    = (~sel_q & r_ldx) ? r_x : 8'd0;
    xpos_b_d    = (sel_q & r_ldx) ? r_x : 8'd0;
    we_a_d      = (~sel_q & r_we) | (sel_d & d_we);
    we_b_d      = (sel_q & r_we) | (~sel_d & d_we);
    mode_a_d    = sel_d & d_mode;
    mode_b_d    = ~sel_d & d_mode;
  end

  assign bus.LDX_A      = ldx_a_q;
  assign bus.LDX_B      = ldx_b_q;
  assign bus.XPOS_A     = xpos_a_q;
  assign bus.XPOS_B     = xpos_b_q;
  assign bus.WE_A       = we_a_q;
  assign bus.WE_B       = we_b_q;
  assign bus.MODE_A     = mode_a_q;
  assign bus.MODE_B     = mode_b_q;
  assign bus.SEL        = sel_q;
  assign bus.DISP_VALID = disp_valid_q;
  assign bus.CLR_EN     = clr_en_q;
  assign bus.LINE_ERR   = line_err_q;
  assign bus.WR_DROP    = wr_drop_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Scoreboard bench for linebuffer_ctrl: each driven cycle queues the expected output vector
// for the following cycle; a negedge monitor pops and compares in cycle order.
module tb_linebuffer_ctrl;
  localparam int DS = 8;
  localparam int LB = 192;
  localparam int W  = 29;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_READ = 2'd2, S_CLEAR = 2'd3;

  logic       CK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] dbg_state;

  linebuffer_ctrl_if lb_if ();

  linebuffer_ctrl #(.DISP_START(DS), .LB_LEN(LB)) dut (
    .CK          (CK),
    .RESET       (RESET),
    .bus         (lb_if),
    .dbg_state_o (dbg_state)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad = 0;

  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic sel,
                                      input logic ldx_a, input logic ldx_b,
                                      input logic [7:0] xa, input logic [7:0] xb,
                                      input logic we_a, input logic we_b,
                                      input logic mode_a, input logic mode_b,
                                      input logic dv, input logic clr,
                                      input logic lerr, input logic drop);
    return {st, sel, ldx_a, ldx_b, xa, xb, we_a, we_b, mode_a, mode_b, dv, clr, lerr, drop};
  endfunction

  function automatic logic [W-1:0] actual();
    return mk(dbg_state, lb_if.SEL, lb_if.LDX_A, lb_if.LDX_B, lb_if.XPOS_A, lb_if.XPOS_B,
              lb_if.WE_A, lb_if.WE_B, lb_if.MODE_A, lb_if.MODE_B, lb_if.DISP_VALID,
              lb_if.CLR_EN, lb_if.LINE_ERR, lb_if.WR_DROP);
  endfunction

  // Expected display behaviour n cycles after the swap edge; s=1 means A is displayed.
  function automatic logic [W-1:0] line_exp(input logic s, input int n);
    logic [1:0] st;
    logic       ldx, rd, cl;
    if (n <= DS - 1)               st = S_WAIT;
    else if (n <= DS + LB - 1)     st = S_READ;
    else if (n <= DS + 2 * LB - 1) st = S_CLEAR;
    else                           st = S_IDLE;
    ldx = (n == DS - 1) || (n == DS + LB - 1);
    rd  = (st == S_READ);
    cl  = (st == S_CLEAR);
    return mk(st, s, s & ldx, ~s & ldx, 8'd0, 8'd0, s & cl, ~s & cl, s & rd, ~s & rd,
              rd, cl, 1'b0, 1'b0);
  endfunction

  // Render-side fields only; bb=1 means buffer B is the render target.
  function automatic logic [W-1:0] rnd_exp(input logic bb, input logic ldx, input logic [7:0] x,
                                           input logic we, input logic drop);
    return mk(S_IDLE, 1'b0, ~bb & ldx, bb & ldx, bb ? 8'd0 : x, bb ? x : 8'd0,
              ~bb & we, bb & we, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, drop);
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, e);
    end
  endtask

  always @(negedge CK) begin
    if (tag_q.size() > 0 && tag_q[0] < cyc) begin
      total++;
      bad++;
      $display("FAIL %s: expectation for cyc %0d not sampled (now %0d)", name_q[0], tag_q[0], cyc);
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
      void'(name_q.pop_front());
    end
    if (tag_q.size() > 0 && tag_q[0] == cyc) begin
      check(name_q[0], actual(), exp_q[0]);
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
      void'(name_q.pop_front());
    end
  end

  // Drive one cycle of inputs from a negedge and queue the response expected after the edge.
  task automatic step(input logic hs, input logic ld, input logic [7:0] x, input logic pv,
                      input logic [W-1:0] e, input string nm);
    lb_if.HSYNC_START = hs;
    lb_if.PIX_LOAD    = ld;
    lb_if.PIX_X       = x;
    lb_if.PIX_VALID   = pv;
    exp_q.push_back(e);
    tag_q.push_back(cyc + 1);
    name_q.push_back(nm);
    @(posedge CK);
    @(negedge CK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] zero_v, idle1, lerr_v;

  initial begin
    zero_v = mk(S_IDLE, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle1  = mk(S_IDLE, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lerr_v = mk(S_IDLE, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lb_if.HSYNC_START = 1'b0;
    lb_if.PIX_LOAD    = 1'b0;
    lb_if.PIX_X       = 8'd0;
    lb_if.PIX_VALID   = 1'b0;
    @(negedge CK);

    repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0, zero_v, "reset_hold");
    RESET = 1'b0;
    repeat (4) step(1'b0, 1'b0, 8'd0, 1'b0, zero_v, "idle_after_reset");

    // Full line with A displayed: WAIT, READ 8..199, CLEAR 200..391, IDLE from 392.
    step(1'b1, 1'b0, 8'd0, 1'b0, line_exp(1'b1, 0), "lineA");
    for (int n = 1; n <= DS + 2 * LB + 3; n++)
      step(1'b0, 1'b0, 8'd0, 1'b0, line_exp(1'b1, n), "lineA");

    // Rendering into B while A is idle.
    step(1'b0, 1'b0, 8'd0,   1'b1, idle1 | rnd_exp(1'b1, 1'b0, 8'd0,   1'b0, 1'b1), "drop_no_pos");
    step(1'b0, 1'b0, 8'd0,   1'b1, idle1 | rnd_exp(1'b1, 1'b0, 8'd0,   1'b0, 1'b1), "drop_no_pos");
    step(1'b0, 1'b1, 8'd20,  1'b0, idle1 | rnd_exp(1'b1, 1'b1, 8'd20,  1'b0, 1'b0), "load20");
    repeat (3)
      step(1'b0, 1'b0, 8'd0, 1'b1, idle1 | rnd_exp(1'b1, 1'b0, 8'd0,   1'b1, 1'b0), "write_b");
    step(1'b0, 1'b1, 8'd200, 1'b1, idle1 | rnd_exp(1'b1, 1'b1, 8'd200, 1'b0, 1'b1), "load_and_valid");
    step(1'b0, 1'b0, 8'd0,   1'b1, idle1 | rnd_exp(1'b1, 1'b0, 8'd0,   1'b1, 1'b0), "write_after_load");
    step(1'b0, 1'b0, 8'd0,   1'b0, idle1, "idle_b");

    // Swap with a write on the same edge: the write lands in B, the pre-swap render buffer.
    step(1'b1, 1'b0, 8'd0, 1'b1, line_exp(1'b0, 0) | rnd_exp(1'b1, 1'b0, 8'd0, 1'b1, 1'b0), "swap_write_old");
    step(1'b0, 1'b0, 8'd0, 1'b1, line_exp(1'b0, 1) | rnd_exp(1'b0, 1'b0, 8'd0, 1'b0, 1'b1), "drop_after_swap");
    for (int n = 2; n <= 100; n++)
      step(1'b0, 1'b0, 8'd0, 1'b0, line_exp(1'b0, n), "lineB");

    // HSYNC during READ cycle 100 aborts the B line and restarts with A displayed.
    step(1'b1, 1'b0, 8'd0, 1'b0, line_exp(1'b1, 0) | lerr_v, "abort");
    for (int m = 1; m <= 250; m++)
      step(1'b0, 1'b0, 8'd0, 1'b0, line_exp(1'b1, m), "lineA2");

    // Asynchronous reset in the middle of CLEAR.
    #2 RESET = 1'b1;
    #1 check("async_reset", actual(), zero_v);
    @(negedge CK);
    repeat (2) step(1'b0, 1'b0, 8'd0, 1'b0, zero_v, "reset_mid_clear");
    RESET = 1'b0;
    repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0, zero_v, "idle_after_reset2");
    repeat (2) @(negedge CK);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
